// File: rtl/riscv_multicycle_ctrl.sv
// Main FSM and ALU decoder for a multicycle RV32I datapath with a shared ALU and memory.
// Includes the custom-1 R-type extension (opcode 0101011) when EN_CUSTOM is set.
module riscv_multicycle_ctrl #(
    parameter bit EN_CUSTOM = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       RegWrite,
    output logic       illegal,
    output logic       retire,
    output logic [3:0] state
);

    localparam int unsigned ST_W = 4;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_CUST = 7'b0101011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    state_e     state_q;
    state_e     state_d;
    state_e     dec_next;
    logic       dec_ok;
    logic [1:0] alu_op;
    logic [3:0] r_code;
    logic       r_ok;
    logic [3:0] c_code;
    logic       c_ok;

    // ALU decode for standard R/I ops and for custom-1 ops, with legality flags
    always_comb begin
        r_code = 4'b0000;
        r_ok   = 1'b1;
        case (funct3)
            3'b000:  r_code = (funct7[5] & op[5]) ? 4'b0001 : 4'b0000;
            3'b010:  r_code = 4'b0101;
            3'b110:  r_code = 4'b0011;
            3'b111:  r_code = 4'b0010;
            default: r_ok   = 1'b0;
        endcase

        c_code = 4'b0000;
        c_ok   = 1'b1;
        case ({funct7, funct3})
            10'b0000000_000: c_code = 4'b1000;
            10'b0000000_001: c_code = 4'b1001;
            10'b0000000_010: c_code = 4'b1010;
            10'b0000001_000: c_code = 4'b1011;
            10'b0000001_001: c_code = 4'b1100;
            10'b0000001_010: c_code = 4'b1101;
            10'b0000001_011: c_code = 4'b1110;
            10'b0000010_000: c_code = 4'b0110;
            10'b0000010_001: c_code = 4'b0111;
            10'b0000011_000: c_code = 4'b1111;
            default:         c_ok   = 1'b0;
        endcase

        case (alu_op)
            2'b00:   ALUControl = 4'b0000;
            2'b01:   ALUControl = 4'b0001;
            2'b10:   ALUControl = r_code;
            default: ALUControl = c_code;
        endcase
    end

    // Opcode dispatch out of DECODE; anything unsupported falls back to FETCH
    always_comb begin
        dec_next = S_FETCH;
        dec_ok   = 1'b1;
        case (op)
            OP_LW, OP_SW: dec_next = S_MEMADR;
            OP_R: begin
                if (r_ok) dec_next = S_EXECR;
                else      dec_ok   = 1'b0;
            end
            OP_CUST: begin
                if (EN_CUSTOM && c_ok) dec_next = S_EXECR;
                else                   dec_ok   = 1'b0;
            end
            OP_I: begin
                if (r_ok) dec_next = S_EXECI;
                else      dec_ok   = 1'b0;
            end
            OP_JAL:  dec_next = S_JAL;
            OP_BEQ:  dec_next = S_BEQ;
            default: dec_ok   = 1'b0;
        endcase
    end

    always_comb begin
        case (state_q)
            S_FETCH:                    state_d = S_DECODE;
            S_DECODE:                   state_d = dec_next;
            S_MEMADR:                   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:                  state_d = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL:    state_d = S_ALUWB;
            default:                    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Moore control decode; enables are forced low while reset is held
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        illegal   = 1'b0;
        retire    = 1'b0;
        alu_op    = 2'b00;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                illegal = ~dec_ok;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = (op == OP_CUST) ? 2'b11 : 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                PCWrite = Zero;
                retire  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
            retire   = 1'b0;
        end
    end

endmodule
